// File: rtl/program_counter.sv
// program_counter -- fetch-stage PC register with programmable step, stall,
// branch load and an optional circular return-address stack (RAS).
//
// Build option: define PC_RAS_EN to build the RAS. Without it, `call` acts
// as a plain branch, `ret` is ignored and the RAS status outputs are constant.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset (overrides enable)
//   enable         1 = advance, 0 = stall (PC and RAS hold)
//   branch_valid   load branch_target as next PC
//   branch_target  jump / call destination
//   call           push pc_out+STEP, jump to branch_target
//   ret            pop top of RAS, jump to popped address
//   pc_out         current PC (registered)
//   ras_count      number of valid RAS entries
//   ras_empty      ras_count == 0
//   ras_full       ras_count == RAS_DEPTH
//   ras_ovf        sticky: push while full
//   ras_unf        sticky: pop while empty
module program_counter #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           branch_valid,
  input  logic [WIDTH-1:0]               branch_target,
  input  logic                           call,
  input  logic                           ret,
  output logic [WIDTH-1:0]               pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int CW = $clog2(RAS_DEPTH+1);

  // Sequential increment; wraps silently modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] add_step(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(STEP);
  endfunction

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus;

  assign pc_plus = add_step(pc_q);
  assign pc_out  = pc_q;

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  // sp_q points at the next free slot; it wraps, so a push while full
  // overwrites the oldest entry and later pops still come out LIFO.
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;

  assign top_idx = sp_q - PW'(1);

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (enable) begin
      if (ret) begin
        if (cnt_q != '0) begin
          pc_d  = ras_mem_q[top_idx];
          sp_d  = top_idx;
          cnt_d = cnt_q - CW'(1);
        end else begin
          pc_d  = pc_plus;
          unf_d = 1'b1;
        end
      end else if (call) begin
        push = 1'b1;
        pc_d = branch_target;
        sp_d = sp_q + PW'(1);
        if (cnt_q == CW'(RAS_DEPTH)) ovf_d = 1'b1;
        else                         cnt_d = cnt_q + CW'(1);
      end else if (branch_valid) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents are data only; a reset simply makes them unreachable.
  always_ff @(posedge clk) begin
    if (!reset && push) ras_mem_q[sp_q] <= pc_plus;
  end

  assign ras_count = cnt_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
`else
  // No stack: call is a plain jump, ret falls through to lower priorities.
  logic unused_ret;
  assign unused_ret = ret;

  always_comb begin
    pc_d = pc_q;
    if (enable) begin
      if (call || branch_valid) pc_d = branch_target;
      else                      pc_d = pc_plus;
    end
  end

  assign ras_count = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver pushes the expected
// post-edge state for every cycle it issues; the monitor pops and compares
// on the falling edge. RAS-specific vectors are built only with PC_RAS_EN.
module tb_program_counter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          branch_valid = 1'b0;
  logic [W-1:0]  branch_target = '0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [W-1:0]  pc_out;
  logic [2:0]    ras_count;
  logic          ras_empty, ras_full, ras_ovf, ras_unf;

  program_counter #(
    .WIDTH(W), .RESET_VECTOR(32'h0), .STEP(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .call(call), .ret(ret), .pc_out(pc_out),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [W-1:0] pc;
    logic [6:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tag_cnt  = 0;

  // Packs {count, empty, full, ovf, unf} for one-shot status comparison.
  function automatic logic [6:0] st(input int c, input bit e, input bit f,
                                    input bit o, input bit u);
    logic [2:0] cc;
    cc = c[2:0];
    return {cc, e, f, o, u};
  endfunction

  // One clock: drive inputs after the falling edge, queue the expectation
  // for the state that must appear after the following rising edge.
  task automatic cyc(input bit rs, input bit en, input bit bv,
                     input logic [W-1:0] tgt, input bit cl, input bit rt,
                     input logic [W-1:0] exp_pc, input logic [6:0] exp_st);
    exp_t e;
    @(negedge clk);
    reset = rs; enable = en; branch_valid = bv;
    branch_target = tgt; call = cl; ret = rt;
    @(posedge clk);
    tag_cnt++;
    e.tag = tag_cnt; e.pc = exp_pc; e.st = exp_st;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [6:0] act_st;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act_st = {ras_count, ras_empty, ras_full, ras_ovf, ras_unf};
        n_assert++;
        if (pc_out !== e.pc) begin
          n_fail++;
          $display("FAIL pc step%0d: got %h expected %h", e.tag, pc_out, e.pc);
        end
        n_assert++;
        if (act_st !== e.st) begin
          n_fail++;
          $display("FAIL status step%0d: got cnt=%0d e=%b f=%b o=%b u=%b expected cnt=%0d e=%b f=%b o=%b u=%b",
                   e.tag, act_st[6:4], act_st[3], act_st[2], act_st[1], act_st[0],
                   e.st[6:4], e.st[3], e.st[2], e.st[1], e.st[0]);
        end
      end
    end
  end

  // Driver
  initial begin
    logic [6:0] idle;
    idle = st(0, 1, 0, 0, 0);

    // Reset, sequential fetch, stall (branch ignored while stalled).
    cyc(1, 0, 0, 32'h0,        0, 0, 32'h0,        idle);
    cyc(0, 1, 0, 32'h0,        0, 0, 32'h4,        idle);
    cyc(0, 1, 0, 32'h0,        0, 0, 32'h8,        idle);
    cyc(0, 1, 0, 32'h0,        0, 0, 32'hC,        idle);
    cyc(0, 0, 0, 32'h0,        0, 0, 32'hC,        idle);
    cyc(0, 0, 1, 32'h1234,     1, 0, 32'hC,        idle);

    // Branch and silent wrap-around.
    cyc(0, 1, 1, 32'hFFFFFFF8, 0, 0, 32'hFFFFFFF8, idle);
    cyc(0, 1, 0, 32'h0,        0, 0, 32'hFFFFFFFC, idle);
    cyc(0, 1, 0, 32'h0,        0, 0, 32'h0,        idle);

`ifdef PC_RAS_EN
    // Nested call / return at full rate.
    cyc(0, 1, 1, 32'h100, 0, 0, 32'h100, idle);
    cyc(0, 1, 0, 32'h200, 1, 0, 32'h200, st(1, 0, 0, 0, 0));
    cyc(0, 1, 0, 32'h300, 1, 0, 32'h300, st(2, 0, 0, 0, 0));
    cyc(0, 1, 0, 32'h0,   0, 1, 32'h204, st(1, 0, 0, 0, 0));
    cyc(0, 1, 0, 32'h0,   0, 1, 32'h104, idle);

    // Overflow: five calls into a four-deep stack.
    cyc(0, 1, 1, 32'h0,  0, 0, 32'h0,  idle);
    cyc(0, 1, 0, 32'h10, 1, 0, 32'h10, st(1, 0, 0, 0, 0));
    cyc(0, 1, 0, 32'h20, 1, 0, 32'h20, st(2, 0, 0, 0, 0));
    cyc(0, 1, 0, 32'h30, 1, 0, 32'h30, st(3, 0, 0, 0, 0));
    cyc(0, 1, 0, 32'h40, 1, 0, 32'h40, st(4, 0, 1, 0, 0));
    cyc(0, 1, 0, 32'h50, 1, 0, 32'h50, st(4, 0, 1, 1, 0));
    // Drain: survivors in LIFO order, then underflow falls through to +STEP.
    cyc(0, 1, 0, 32'h0, 0, 1, 32'h44, st(3, 0, 0, 1, 0));
    cyc(0, 1, 0, 32'h0, 0, 1, 32'h34, st(2, 0, 0, 1, 0));
    cyc(0, 1, 0, 32'h0, 0, 1, 32'h24, st(1, 0, 0, 1, 0));
    cyc(0, 1, 0, 32'h0, 0, 1, 32'h14, st(0, 1, 0, 1, 0));
    cyc(0, 1, 0, 32'h0, 0, 1, 32'h18, st(0, 1, 0, 1, 1));

    // Priority: ret beats call and branch; no push happens.
    cyc(0, 1, 0, 32'h80,  1, 0, 32'h80, st(1, 0, 0, 1, 1));
    cyc(0, 1, 1, 32'h900, 1, 1, 32'h1C, st(0, 1, 0, 1, 1));

    // Reset with enable low during a call clears everything.
    cyc(1, 0, 0, 32'h700, 1, 0, 32'h0, idle);
    cyc(0, 1, 0, 32'h0,   0, 0, 32'h4, idle);
    // Reset mid call-chain discards the stacked entry.
    cyc(0, 1, 0, 32'h600, 1, 0, 32'h600, st(1, 0, 0, 0, 0));
    cyc(1, 1, 0, 32'h650, 1, 0, 32'h0,   idle);
    cyc(0, 1, 0, 32'h0,   0, 1, 32'h4,   st(0, 1, 0, 0, 1));
`else
    // Without the stack: call is a jump, ret is ignored.
    cyc(0, 1, 0, 32'h500, 1, 0, 32'h500, idle);
    cyc(0, 1, 0, 32'h0,   0, 1, 32'h504, idle);
    cyc(0, 1, 1, 32'h700, 0, 1, 32'h700, idle);
    cyc(0, 1, 0, 32'h800, 1, 1, 32'h800, idle);
    cyc(0, 0, 0, 32'h900, 1, 0, 32'h800, idle);
    cyc(1, 0, 0, 32'h900, 1, 0, 32'h0,   idle);
    cyc(0, 1, 0, 32'h0,   0, 0, 32'h4,   idle);
`endif

    cyc(0, 0, 0, 32'h0, 0, 0, pc_expected_last(), sb_last_st());

    // Let the monitor drain, bounded.
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // A stalled final cycle must repeat the previous expectation.
  logic [W-1:0] last_pc;
  logic [6:0]   last_st;
  always @(posedge clk) begin
    if (sb.size() > 0) begin
      last_pc <= sb[sb.size()-1].pc;
      last_st <= sb[sb.size()-1].st;
    end
  end

  function automatic logic [W-1:0] pc_expected_last();
`ifdef PC_RAS_EN
    return 32'h4;
`else
    return 32'h4;
`endif
  endfunction

  function automatic logic [6:0] sb_last_st();
`ifdef PC_RAS_EN
    return st(0, 1, 0, 0, 1);
`else
    return st(0, 1, 0, 0, 0);
`endif
  endfunction

endmodule
